// File: rtl/reg_writeback_queue.sv
// In-order register write-back queue feeding a single register-file write port,
// with newest-first forwarding lookup across every pending write.
module reg_writeback_queue #(
    parameter int WIDTH    = 32,
    parameter int SELECTOR = 5,
    parameter int DEPTH    = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       Req_Valid_i,
    input  logic [SELECTOR-1:0]        Req_Register_i,
    input  logic [WIDTH-1:0]           Req_Data_i,
    output logic                       Req_Ready_o,
    input  logic                       Drain_En_i,
    output logic                       Reg_Write_o,
    output logic [SELECTOR-1:0]        Write_Register_o,
    output logic [WIDTH-1:0]           Write_Data_o,
    input  logic [SELECTOR-1:0]        Lookup_Register_1_i,
    input  logic [SELECTOR-1:0]        Lookup_Register_2_i,
    output logic                       Hit_1_o,
    output logic                       Hit_2_o,
    output logic [WIDTH-1:0]           Fwd_Data_1_o,
    output logic [WIDTH-1:0]           Fwd_Data_2_o,
    output logic [$clog2(DEPTH):0]     Count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [SELECTOR-1:0] rd_mem_q [DEPTH];
    logic [WIDTH-1:0]    data_mem_q [DEPTH];

    logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]       count_q, count_d;
    logic                wen_q, wen_d;
    logic [SELECTOR-1:0] wreg_q, wreg_d;
    logic [WIDTH-1:0]    wdata_q, wdata_d;

    logic push, pop;
    logic [PW-1:0] idx;

    assign Req_Ready_o = !rst && (count_q < CW'(DEPTH));
    // Writes to register 0 complete the handshake but never occupy an entry.
    assign push = Req_Valid_i && Req_Ready_o && (Req_Register_i != '0);
    assign pop  = Drain_En_i && (count_q != '0) && !rst;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        wen_d    = 1'b0;
        wreg_d   = wreg_q;
        wdata_d  = wdata_q;
        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
            wen_d    = 1'b1;
            wreg_d   = rd_mem_q[rd_ptr_q];
            wdata_d  = data_mem_q[rd_ptr_q];
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            wen_q    <= 1'b0;
            wreg_q   <= '0;
            wdata_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            wen_q    <= wen_d;
            wreg_q   <= wreg_d;
            wdata_q  <= wdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            rd_mem_q[wr_ptr_q]   <= Req_Register_i;
            data_mem_q[wr_ptr_q] <= Req_Data_i;
        end
    end

    // Output stage is oldest; walking head to tail lets newer entries override.
    always_comb begin
        Hit_1_o      = 1'b0;
        Hit_2_o      = 1'b0;
        Fwd_Data_1_o = '0;
        Fwd_Data_2_o = '0;
        idx          = '0;
        if (wen_q && wreg_q == Lookup_Register_1_i) begin
            Hit_1_o      = 1'b1;
            Fwd_Data_1_o = wdata_q;
        end
        if (wen_q && wreg_q == Lookup_Register_2_i) begin
            Hit_2_o      = 1'b1;
            Fwd_Data_2_o = wdata_q;
        end
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr_q + PW'(i);
            if (CW'(i) < count_q) begin
                if (rd_mem_q[idx] == Lookup_Register_1_i) begin
                    Hit_1_o      = 1'b1;
                    Fwd_Data_1_o = data_mem_q[idx];
                end
                if (rd_mem_q[idx] == Lookup_Register_2_i) begin
                    Hit_2_o      = 1'b1;
                    Fwd_Data_2_o = data_mem_q[idx];
                end
            end
        end
        if (Lookup_Register_1_i == '0) begin
            Hit_1_o      = 1'b0;
            Fwd_Data_1_o = '0;
        end
        if (Lookup_Register_2_i == '0) begin
            Hit_2_o      = 1'b0;
            Fwd_Data_2_o = '0;
        end
    end

    assign Reg_Write_o      = wen_q;
    assign Write_Register_o = wreg_q;
    assign Write_Data_o     = wdata_q;
    assign Count_o          = count_q;

endmodule

// File: doc/reg_writeback_queue.md
REG_WRITEBACK_QUEUE -- requirements
Module: reg_writeback_queue

Interface
REQ-001 Parameters SHALL be, one per line:
  - WIDTH, 32, data width of each register.
  - SELECTOR, 5, register address width.
  - DEPTH, 4, queue entries (power of two, at least 2).
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
  - clk  in  1  the single clock; all state updates on the rising edge.
  - rst  in  1  reset, synchronous, active-high.
  - Req_Valid_i  in  1  write request present.
  - Req_Register_i  in  SELECTOR  destination register (rd).
  - Req_Data_i  in  WIDTH  value to write (R[rd]).
  - Req_Ready_o  out  1  queue can accept a request.
  - Drain_En_i  in  1  register-file write port is available this cycle.
  - Reg_Write_o  out  1  write enable to the register file.
  - Write_Register_o  out  SELECTOR  register-file write address.
  - Write_Data_o  out  WIDTH  register-file write data.
  - Lookup_Register_1_i  in  SELECTOR  rs number for forwarding lookup.
  - Lookup_Register_2_i  in  SELECTOR  rt number for forwarding lookup.
  - Hit_1_o  out  1  a write to Lookup_Register_1_i is pending.
  - Hit_2_o  out  1  a write to Lookup_Register_2_i is pending.
  - Fwd_Data_1_o  out  WIDTH  newest pending value for rs.
  - Fwd_Data_2_o  out  WIDTH  newest pending value for rt.
  - Count_o  out  $clog2(DEPTH)+1  number of valid queue entries.

Function
REQ-003 The block SHALL buffer register writes in FIFO order and issue them to the register-file write port, one write per cycle at most.
REQ-004 Accept rule: a request is accepted at an edge when Req_Valid_i=1, Req_Ready_o=1 and rst=0.
REQ-005 Req_Ready_o SHALL be combinational and equal 1 exactly when rst=0 and Count_o<DEPTH.
  - When the queue is full there is no pass-through acceptance, even if a pop occurs in the same cycle.
REQ-006 An accepted request with Req_Register_i=0 SHALL be consumed and discarded: no entry is created and Count_o is unchanged.
REQ-007 Pop rule: a pop occurs at an edge when Drain_En_i=1, Count_o>0 and rst=0. On a pop:
  - the head entry is loaded into the Write_Register_o / Write_Data_o output registers;
  - Reg_Write_o is 1 for exactly the following cycle.
REQ-008 At any edge without a pop, Reg_Write_o SHALL become 0. Write_Register_o and Write_Data_o SHALL hold their last values.
REQ-009 An entry pushed at an edge SHALL NOT be popped at that same edge.
  - Minimum latency: accept at edge N, pop at edge N+1, Reg_Write_o=1 in the cycle after edge N+1.
REQ-010 Count update per edge: +1 for push only, -1 for pop only, unchanged for both or neither.
REQ-011 Read and write pointers SHALL wrap modulo DEPTH. Entries are issued in exact acceptance order.
REQ-012 Lookup SHALL be combinational over all pending writes: every valid queue entry plus the output stage while Reg_Write_o=1.
REQ-013 Lookup priority SHALL go to the newest matching write: queue entries from tail to head first, then the output stage.
REQ-014 Lookup register 0 SHALL always return Hit=0 and Fwd_Data=0. A miss SHALL return Fwd_Data=0.
REQ-015 Both lookup ports SHALL be independent and may address the same register.

Reset
REQ-016 While rst=1 at an edge, the block SHALL:
  - set Count_o=0 and both pointers to 0;
  - set Reg_Write_o=0, Write_Register_o=0, Write_Data_o=0;
  - ignore any request and any pop.
REQ-017 Reset in mid-operation SHALL discard all pending entries without issuing them. No Reg_Write_o pulse occurs after the reset edge.
REQ-018 In the cycle after reset release, Hit_1_o=Hit_2_o=0, Fwd_Data_1_o=Fwd_Data_2_o=0 and Req_Ready_o=1.

Verification
REQ-019 Single write: push (rd=5, 0xDEADBEEF) at edge 1 with Drain_En_i=1 -> Reg_Write_o=1, Write_Register_o=5, Write_Data_o=0xDEADBEEF in the cycle after edge 2 only.
REQ-020 Fill and order: with Drain_En_i=0, push rd=1..4 with data 0x11..0x44 -> Count_o=4, Req_Ready_o=0, and a fifth request is not accepted. Then set Drain_En_i=1 -> writes issue as 1,2,3,4 on consecutive cycles and Count_o returns to 0.
REQ-021 Zero register: push rd=0 with data 0xFFFFFFFF -> handshake completes, Count_o stays 0, no Reg_Write_o pulse, and lookup of register 0 gives Hit=0, Fwd=0.
REQ-022 Forwarding: with Drain_En_i=0, push (rd=7, 0xA) then (rd=7, 0xB). Lookup 1 = 7 -> Hit_1_o=1, Fwd_Data_1_o=0xB. Lookup 2 = 8 -> Hit_2_o=0, Fwd_Data_2_o=0.
REQ-023 Simultaneous push and pop: at Count_o=2, push and pop at the same edge -> Count_o stays 2 and FIFO order is preserved across pointer wrap-around.
REQ-024 Reset mid-drain: at Count_o=3 with Drain_En_i=1, assert rst for one edge -> Reg_Write_o=0 from that edge onward, Count_o=0, and none of the remaining entries are ever issued.
